// File: rtl/ks_addsub_pipe_if.sv
// Handshake bundle for the pipelined Kogge-Stone adder/subtractor.
// The operand side flows into the block and the result side flows out of it.
interface ks_addsub_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic             out_zero;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
  );
endinterface

// File: rtl/ks_addsub_pipe.sv
// Three-stage Kogge-Stone adder/subtractor: operand capture, lower prefix levels,
// then upper prefix levels plus sum/flag formation into the output register.
module ks_addsub_pipe #(
  parameter int WIDTH = 16,
  parameter int SPLIT = $clog2(WIDTH) / 2
) (
  input  logic          clk,
  input  logic          rst_n,
  ks_addsub_pipe_if.slave bus
);

  localparam int LEVELS = $clog2(WIDTH);

  function automatic logic [1:0] gp_combine(input logic g_hi, input logic p_hi,
                                            input logic g_lo, input logic p_lo);
    return {g_hi | (g_lo & p_hi), p_hi & p_lo};
  endfunction

  logic             vld_p0, vld_p1, vld_p2;
  logic             adv_p0, adv_p1, adv_p2;
  logic [WIDTH-1:0] b_mod;
  logic [WIDTH-1:0] g_p0, p_p0;
  logic             c0_p0;
  logic [WIDTH-1:0] g_s2, p_s2, g_t2, p_t2;
  logic [WIDTH-1:0] g_p1, p_p1, x_p1;
  logic             c0_p1;
  logic [WIDTH-1:0] g_s3, p_s3, g_t3, p_t3;
  logic [WIDTH-1:0] sum_s3;
  logic [WIDTH-1:0] sum_p2;
  logic             cout_p2, ovf_p2, zero_p2;

  // A stage may load whenever it is empty or its contents move on this edge.
  assign adv_p2       = ~vld_p2 | bus.out_ready;
  assign adv_p1       = ~vld_p1 | adv_p2;
  assign adv_p0       = ~vld_p0 | adv_p1;
  assign bus.in_ready = adv_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (adv_p0) vld_p0 <= bus.in_valid;
      if (adv_p1) vld_p1 <= vld_p0;
      if (adv_p2) vld_p2 <= vld_p1;
    end
  end

  // ---- stage 1: operand conditioning and per-bit generate/propagate ----
  assign b_mod = bus.in_sub ? ~bus.in_b : bus.in_b;

  always_ff @(posedge clk) begin
    if (adv_p0) begin
      g_p0  <= bus.in_a & b_mod;
      p_p0  <= bus.in_a ^ b_mod;
      c0_p0 <= bus.in_sub | bus.in_cin;
    end
  end

  // ---- stage 2: carry-in folded into bit 0, then prefix levels 1..SPLIT ----
  always_comb begin
    g_s2    = g_p0;
    p_s2    = p_p0;
    g_s2[0] = g_p0[0] | (p_p0[0] & c0_p0);
    p_s2[0] = 1'b0;
    g_t2    = '0;
    p_t2    = '0;
    for (int l = 0; l < SPLIT; l++) begin
      g_t2 = g_s2;
      p_t2 = p_s2;
      for (int i = (1 << l); i < WIDTH; i++) begin
        {g_s2[i], p_s2[i]} = gp_combine(g_t2[i], p_t2[i], g_t2[i-(1<<l)], p_t2[i-(1<<l)]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (adv_p1) begin
      g_p1  <= g_s2;
      p_p1  <= p_s2;
      x_p1  <= p_p0;
      c0_p1 <= c0_p0;
    end
  end

  // ---- stage 3: remaining prefix levels; g_s3[i] is the carry out of bit i ----
  always_comb begin
    g_s3 = g_p1;
    p_s3 = p_p1;
    g_t3 = '0;
    p_t3 = '0;
    for (int l = SPLIT; l < LEVELS; l++) begin
      g_t3 = g_s3;
      p_t3 = p_s3;
      for (int i = (1 << l); i < WIDTH; i++) begin
        {g_s3[i], p_s3[i]} = gp_combine(g_t3[i], p_t3[i], g_t3[i-(1<<l)], p_t3[i-(1<<l)]);
      end
    end
    sum_s3 = x_p1 ^ {g_s3[WIDTH-2:0], c0_p1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_p2  <= '0;
      cout_p2 <= 1'b0;
      ovf_p2  <= 1'b0;
      zero_p2 <= 1'b0;
    end else if (adv_p2 && vld_p1) begin
      sum_p2  <= sum_s3;
      cout_p2 <= g_s3[WIDTH-1];
      ovf_p2  <= g_s3[WIDTH-1] ^ g_s3[WIDTH-2];
      zero_p2 <= (sum_s3 == '0);
    end
  end

  assign bus.out_valid = vld_p2;
  assign bus.out_sum   = sum_p2;
  assign bus.out_cout  = cout_p2;
  assign bus.out_ovf   = ovf_p2;
  assign bus.out_zero  = zero_p2;

endmodule

// File: tb/tb_ks_addsub_pipe.sv
// Scoreboard bench for ks_addsub_pipe: expected results are queued at input
// handshakes from an integer-arithmetic model and popped at output handshakes.
module tb_ks_addsub_pipe;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  bit   rand_bp = 0;
  bit   stream_done;
  res_t exp_q[$];

  ks_addsub_pipe_if #(.WIDTH(16)) bus ();

  ks_addsub_pipe #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic sub);
    res_t r;
    int ua = a;
    int ub = b;
    int sa = $signed(a);
    int sbv = $signed(b);
    int full, sfull;
    if (sub) begin
      full   = ua - ub;
      sfull  = sa - sbv;
      r.cout = (ua >= ub);
    end else begin
      full   = ua + ub + int'(cin);
      sfull  = sa + sbv + int'(cin);
      r.cout = (full >= 65536);
    end
    r.sum  = full[15:0];
    r.ovf  = (sfull > 32767) || (sfull < -32768);
    r.zero = (r.sum == 16'h0000);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Input-side observer: every accepted operation queues its expected result.
  always @(negedge clk) begin
    if (rst_n && bus.in_valid && bus.in_ready)
      exp_q.push_back(model(bus.in_a, bus.in_b, bus.in_cin, bus.in_sub));
  end

  // Output-side monitor: every completed result transfer is checked in order.
  always @(negedge clk) begin
    res_t e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sum",  bus.out_sum,  e.sum);
        chk("cout", bus.out_cout, e.cout);
        chk("ovf",  bus.out_ovf,  e.ovf);
        chk("zero", bus.out_zero, e.zero);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_bp) bus.out_ready = ($urandom_range(0, 3) != 0);
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [15:0] a, input logic [15:0] b,
                      input logic cin, input logic sub);
    logic acc;
    acc         = 1'b0;
    bus.in_a    = a;
    bus.in_b    = b;
    bus.in_cin  = cin;
    bus.in_sub  = sub;
    bus.in_valid = 1'b1;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic directed(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub, input logic [15:0] s,
                          input logic co, input logic ov, input logic z);
    send(a, b, cin, sub);
    @(negedge clk);
    chk({name, "_lat1"}, bus.out_valid, 32'd0);
    @(negedge clk);
    chk({name, "_lat2"}, bus.out_valid, 32'd0);
    @(negedge clk);
    chk({name, "_lat3"}, bus.out_valid, 32'd1);
    chk({name, "_sum"},  bus.out_sum,  s);
    chk({name, "_cout"}, bus.out_cout, co);
    chk({name, "_ovf"},  bus.out_ovf,  ov);
    chk({name, "_zero"}, bus.out_zero, z);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    for (int n = 0; n < 200; n++) begin
      if (exp_q.size() == 0 && !bus.out_valid) break;
      @(negedge clk);
    end
    chk({name, "_drained"}, exp_q.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h7FFF;
      3:       return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    logic [15:0] ba[6];
    logic [15:0] bb[6];
    logic        bs[6];
    res_t        r0;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cin    = 1'b0;
    bus.in_sub    = 1'b0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #2;
    chk("rst_out_valid", bus.out_valid, 32'd0);
    chk("rst_out_sum",   bus.out_sum,   32'd0);
    chk("rst_flags",     {bus.out_cout, bus.out_ovf, bus.out_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 32'd1);

    directed("add",      16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
    directed("wrap",     16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    directed("posovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    directed("borrow",   16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    directed("subovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    directed("subcin",   16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    directed("subzero",  16'hABCD, 16'hABCD, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);

    // Backpressure: six back-to-back ops against a stalled consumer.
    for (int k = 0; k < 6; k++) begin
      ba[k] = 16'($urandom);
      bb[k] = 16'($urandom);
      bs[k] = 1'($urandom);
    end
    r0 = model(ba[0], bb[0], 1'b0, bs[0]);
    bus.out_ready = 1'b0;
    stream_done   = 1'b0;
    fork
      begin
        for (int k = 0; k < 6; k++) send(ba[k], bb[k], 1'b0, bs[k]);
        stream_done = 1'b1;
      end
    join_none
    repeat (8) @(negedge clk);
    chk("bp_in_ready_low", bus.in_ready, 32'd0);
    chk("bp_out_valid", bus.out_valid, 32'd1);
    for (int k = 0; k < 3; k++) begin
      chk("bp_sum_hold", bus.out_sum, r0.sum);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("simul_in_ready", bus.in_ready, 32'd1);
    chk("simul_out_valid", bus.out_valid, 32'd1);
    for (int n = 0; n < 100 && !stream_done; n++) @(posedge clk);
    chk("bp_stream_done", stream_done, 32'd1);
    #1;
    drain("bp");

    // Reset with two operations still inside the pipe.
    send(16'h1111, 16'h2222, 1'b0, 1'b0);
    send(16'h3333, 16'h0001, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_out_valid", bus.out_valid, 32'd0);
    chk("midrst_out_sum",   bus.out_sum,   32'd0);
    chk("midrst_flags",     {bus.out_cout, bus.out_ovf, bus.out_zero}, 32'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("midrst_no_stale", bus.out_valid, 32'd0);
    end
    @(posedge clk);
    #1;

    // Random traffic with random consumer stalls.
    rand_bp = 1'b1;
    for (int k = 0; k < 10000; k++) begin
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end else begin
        send(pick_operand(), pick_operand(), 1'($urandom), 1'($urandom));
      end
    end
    rand_bp = 1'b0;
    @(posedge clk);
    #2;
    bus.out_ready = 1'b1;
    drain("random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ks_addsub_pipe.md
Name: ks_addsub_pipe

Overview:
- Pipelined Kogge-Stone adder/subtractor with valid/ready handshakes on input and output.
- Subtraction is the inverse operation of the existing combinational prefix adder. It is built from the same generate/propagate window-combine cells.
- The prefix tree is split across three register stages so the datapath can be instantiated at full clock rate.
- Accepts one operation per cycle under no backpressure. Returns sum/difference plus carry, signed-overflow and zero flags.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be a power of two, ≥4. Number of prefix levels is log2(WIDTH).
- SPLIT, log2(WIDTH)/2 (integer floor), number of prefix levels evaluated in stage 2. The remaining levels are evaluated in stage 3.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands and op present
- in_ready  out  1  block can accept an operation this cycle
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_cin  in  1  carry-in. Used for add only; ignored for sub.
- in_sub  in  1  0: A+B+cin; 1: A-B, computed as A+~B+1
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- out_sum  out  WIDTH  result, modulo 2^WIDTH
- out_cout  out  1  carry-out. For sub, 1 means no borrow (A ≥ B unsigned).
- out_ovf  out  1  signed two's-complement overflow
- out_zero  out  1  out_sum == 0

Behaviour:
- Reset (async assert, sync-to-clk deassert is the integrator's job):
  - all stage valid bits = 0; out_valid = 0.
  - out_sum, out_cout, out_ovf, out_zero = 0.
  - in_ready = 1 one cycle after reset deassertion, and combinationally whenever the pipe has room.
- Stage 1 (capture): on in_valid && in_ready, register:
  - b' = in_sub ? ~in_b : in_b
  - c0 = in_sub ? 1 : in_cin
  - per-bit g = a & b', p = a ^ b'
  - sign bits a[W-1], b'[W-1]
- Stage 2: apply prefix levels 1..SPLIT with the window combine: G = Ghi | (Glo & Phi), P = Phi & Plo, at distances 1, 2, 4, …. Carry-in is folded in as bit −1 (g = c0, p = 0).
- Stage 3: apply remaining levels. Then:
  - sum[i] = p[i] ^ C[i-1], with C[-1] = c0
  - cout = C[W-1]
  - ovf = C[W-1] ^ C[W-2]
  - zero = (sum == 0)
  - Register all into the output stage.
- Latency: exactly 3 clk edges from the accepting edge to out_valid = 1, when out_ready is held 1.
- Throughput: 1 op/cycle.
- Handshake, per stage k: advance_k = ~valid_k | advance_{k+1}; advance at the output is ~out_valid | out_ready; in_ready = advance_1.
  - Bubbles collapse: an empty stage accepts even while downstream is stalled.
  - in_ready may depend combinationally on out_ready. No combinational path from in_valid to out_valid.
- Stall: while out_valid && !out_ready, out_* hold stable. Upstream stages fill, then in_ready drops when all 3 stages are valid.
- Simultaneous: out pops and in pushes in the same cycle when full → both complete, no loss, no duplication.
- Wrap-around: results are modulo 2^WIDTH. The wrap is reported via cout/ovf only.
- Reset mid-operation discards all in-flight ops. No output is produced for them.
- Flags are valid only when out_valid = 1. Data registers do not need clearing on pop.

Test Plan (WIDTH=16):
- Add: A=0x1234, B=0x4321, cin=0, sub=0 → after 3 cycles: sum=0x5555, cout=0, ovf=0, zero=0.
- Carry/zero wrap: A=0xFFFF, B=0x0000, cin=1 → sum=0x0000, cout=1, ovf=0, zero=1. Separately, A=0x7FFF, B=0x0001 → sum=0x8000, ovf=1, cout=0.
- Sub/borrow: A=0x0005, B=0x0007, sub=1 → sum=0xFFFE, cout=0. A=0x8000, B=0x0001, sub=1 → sum=0x7FFF, ovf=1, cout=1. in_cin=1 with sub has no effect.
- Backpressure: stream 6 ops back-to-back, hold out_ready=0 from cycle 2 → in_ready=0 once 3 ops are held; out_sum stable. Release → results emerge in order, one per cycle, none lost or duplicated.
- Bubble/simultaneous: pipe full, out_ready=1 and in_valid=1 on the same cycle → one result out, one op in. Random 10k-op run against a behavioural A±B model has zero mismatches.
- Reset mid-flight: 2 ops in flight, pulse rst_n low asynchronously between edges → out_valid=0 and all outputs 0 immediately. No stale result appears after release.
